// File: rtl/array_pkg.sv
// Shared sizing and operand/accumulator types for the 16x16 systolic matrix-multiply array.
package array_pkg;
    localparam int N      = 16;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 33;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: forwards its operands right/down and accumulates a*b in place.
module systolic_pe
    import array_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  data_t a_in,
    input  data_t b_in,
    output data_t a_out,
    output data_t b_out,
    output acc_t  acc
);

    // Full-width unsigned product, zero-extended; the sum wraps modulo 2^ACC_W.
    function automatic acc_t mac_wrap(input acc_t acc_v, input data_t a, input data_t b);
        logic [2*DATA_W-1:0] prod;
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        return acc_v + acc_t'(prod);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= mac_wrap(acc, a_in, b_in);
        end
    end

endmodule

// File: rtl/array_16x16.sv
// 16x16 output-stationary systolic array; flat a/b/c ports mapped onto the internal PE grid.
module array_16x16
    import array_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, a14, a15, a16,
    input  logic [DATA_W-1:0] b1, b2, b3, b4, b5, b6, b7, b8, b9, b10, b11, b12, b13, b14, b15, b16,
    output logic [ACC_W-1:0]  c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, c15, c16,
    output logic [ACC_W-1:0]  c17, c18, c19, c20, c21, c22, c23, c24, c25, c26, c27, c28, c29, c30, c31, c32,
    output logic [ACC_W-1:0]  c33, c34, c35, c36, c37, c38, c39, c40, c41, c42, c43, c44, c45, c46, c47, c48,
    output logic [ACC_W-1:0]  c49, c50, c51, c52, c53, c54, c55, c56, c57, c58, c59, c60, c61, c62, c63, c64,
    output logic [ACC_W-1:0]  c65, c66, c67, c68, c69, c70, c71, c72, c73, c74, c75, c76, c77, c78, c79, c80,
    output logic [ACC_W-1:0]  c81, c82, c83, c84, c85, c86, c87, c88, c89, c90, c91, c92, c93, c94, c95, c96,
    output logic [ACC_W-1:0]  c97, c98, c99, c100, c101, c102, c103, c104, c105, c106, c107, c108, c109, c110, c111, c112,
    output logic [ACC_W-1:0]  c113, c114, c115, c116, c117, c118, c119, c120, c121, c122, c123, c124, c125, c126, c127, c128,
    output logic [ACC_W-1:0]  c129, c130, c131, c132, c133, c134, c135, c136, c137, c138, c139, c140, c141, c142, c143, c144,
    output logic [ACC_W-1:0]  c145, c146, c147, c148, c149, c150, c151, c152, c153, c154, c155, c156, c157, c158, c159, c160,
    output logic [ACC_W-1:0]  c161, c162, c163, c164, c165, c166, c167, c168, c169, c170, c171, c172, c173, c174, c175, c176,
    output logic [ACC_W-1:0]  c177, c178, c179, c180, c181, c182, c183, c184, c185, c186, c187, c188, c189, c190, c191, c192,
    output logic [ACC_W-1:0]  c193, c194, c195, c196, c197, c198, c199, c200, c201, c202, c203, c204, c205, c206, c207, c208,
    output logic [ACC_W-1:0]  c209, c210, c211, c212, c213, c214, c215, c216, c217, c218, c219, c220, c221, c222, c223, c224,
    output logic [ACC_W-1:0]  c225, c226, c227, c228, c229, c230, c231, c232, c233, c234, c235, c236, c237, c238, c239, c240,
    output logic [ACC_W-1:0]  c241, c242, c243, c244, c245, c246, c247, c248, c249, c250, c251, c252, c253, c254, c255, c256
);

    data_t a_edge [N];
    data_t b_edge [N];
    data_t a_src  [N][N];
    data_t b_src  [N][N];
    data_t a_w    [N][N];
    data_t b_w    [N][N];
    acc_t  c_arr  [N][N];

    assign a_edge[0]  = a1;  assign a_edge[1]  = a2;  assign a_edge[2]  = a3;  assign a_edge[3]  = a4;
    assign a_edge[4]  = a5;  assign a_edge[5]  = a6;  assign a_edge[6]  = a7;  assign a_edge[7]  = a8;
    assign a_edge[8]  = a9;  assign a_edge[9]  = a10; assign a_edge[10] = a11; assign a_edge[11] = a12;
    assign a_edge[12] = a13; assign a_edge[13] = a14; assign a_edge[14] = a15; assign a_edge[15] = a16;
    assign b_edge[0]  = b1;  assign b_edge[1]  = b2;  assign b_edge[2]  = b3;  assign b_edge[3]  = b4;
    assign b_edge[4]  = b5;  assign b_edge[5]  = b6;  assign b_edge[6]  = b7;  assign b_edge[7]  = b8;
    assign b_edge[8]  = b9;  assign b_edge[9]  = b10; assign b_edge[10] = b11; assign b_edge[11] = b12;
    assign b_edge[12] = b13; assign b_edge[13] = b14; assign b_edge[14] = b15; assign b_edge[15] = b16;

    // Edge PEs take the external operands; interior PEs take their left/upper neighbour's registers.
    genvar r, k;
    generate
        for (r = 0; r < N; r++) begin : g_row
            for (k = 0; k < N; k++) begin : g_col
                if (k == 0) begin : g_a_edge
                    assign a_src[r][k] = a_edge[r];
                end else begin : g_a_chain
                    assign a_src[r][k] = a_w[r][k-1];
                end
                if (r == 0) begin : g_b_edge
                    assign b_src[r][k] = b_edge[k];
                end else begin : g_b_chain
                    assign b_src[r][k] = b_w[r-1][k];
                end
                systolic_pe u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .a_in  (a_src[r][k]),
                    .b_in  (b_src[r][k]),
                    .a_out (a_w[r][k]),
                    .b_out (b_w[r][k]),
                    .acc   (c_arr[r][k])
                );
            end
        end
    endgenerate

    assign c1   = c_arr[0][0];   assign c2   = c_arr[0][1];   assign c3   = c_arr[0][2];   assign c4   = c_arr[0][3];   assign c5   = c_arr[0][4];   assign c6   = c_arr[0][5];   assign c7   = c_arr[0][6];   assign c8   = c_arr[0][7];
    assign c9   = c_arr[0][8];   assign c10  = c_arr[0][9];   assign c11  = c_arr[0][10];  assign c12  = c_arr[0][11];  assign c13  = c_arr[0][12];  assign c14  = c_arr[0][13];  assign c15  = c_arr[0][14];  assign c16  = c_arr[0][15];
    assign c17  = c_arr[1][0];   assign c18  = c_arr[1][1];   assign c19  = c_arr[1][2];   assign c20  = c_arr[1][3];   assign c21  = c_arr[1][4];   assign c22  = c_arr[1][5];   assign c23  = c_arr[1][6];   assign c24  = c_arr[1][7];
    assign c25  = c_arr[1][8];   assign c26  = c_arr[1][9];   assign c27  = c_arr[1][10];  assign c28  = c_arr[1][11];  assign c29  = c_arr[1][12];  assign c30  = c_arr[1][13];  assign c31  = c_arr[1][14];  assign c32  = c_arr[1][15];
    assign c33  = c_arr[2][0];   assign c34  = c_arr[2][1];   assign c35  = c_arr[2][2];   assign c36  = c_arr[2][3];   assign c37  = c_arr[2][4];   assign c38  = c_arr[2][5];   assign c39  = c_arr[2][6];   assign c40  = c_arr[2][7];
    assign c41  = c_arr[2][8];   assign c42  = c_arr[2][9];   assign c43  = c_arr[2][10];  assign c44  = c_arr[2][11];  assign c45  = c_arr[2][12];  assign c46  = c_arr[2][13];  assign c47  = c_arr[2][14];  assign c48  = c_arr[2][15];
    assign c49  = c_arr[3][0];   assign c50  = c_arr[3][1];   assign c51  = c_arr[3][2];   assign c52  = c_arr[3][3];   assign c53  = c_arr[3][4];   assign c54  = c_arr[3][5];   assign c55  = c_arr[3][6];   assign c56  = c_arr[3][7];
    assign c57  = c_arr[3][8];   assign c58  = c_arr[3][9];   assign c59  = c_arr[3][10];  assign c60  = c_arr[3][11];  assign c61  = c_arr[3][12];  assign c62  = c_arr[3][13];  assign c63  = c_arr[3][14];  assign c64  = c_arr[3][15];
    assign c65  = c_arr[4][0];   assign c66  = c_arr[4][1];   assign c67  = c_arr[4][2];   assign c68  = c_arr[4][3];   assign c69  = c_arr[4][4];   assign c70  = c_arr[4][5];   assign c71  = c_arr[4][6];   assign c72  = c_arr[4][7];
    assign c73  = c_arr[4][8];   assign c74  = c_arr[4][9];   assign c75  = c_arr[4][10];  assign c76  = c_arr[4][11];  assign c77  = c_arr[4][12];  assign c78  = c_arr[4][13];  assign c79  = c_arr[4][14];  assign c80  = c_arr[4][15];
    assign c81  = c_arr[5][0];   assign c82  = c_arr[5][1];   assign c83  = c_arr[5][2];   assign c84  = c_arr[5][3];   assign c85  = c_arr[5][4];   assign c86  = c_arr[5][5];   assign c87  = c_arr[5][6];   assign c88  = c_arr[5][7];
    assign c89  = c_arr[5][8];   assign c90  = c_arr[5][9];   assign c91  = c_arr[5][10];  assign c92  = c_arr[5][11];  assign c93  = c_arr[5][12];  assign c94  = c_arr[5][13];  assign c95  = c_arr[5][14];  assign c96  = c_arr[5][15];
    assign c97  = c_arr[6][0];   assign c98  = c_arr[6][1];   assign c99  = c_arr[6][2];   assign c100 = c_arr[6][3];   assign c101 = c_arr[6][4];   assign c102 = c_arr[6][5];   assign c103 = c_arr[6][6];   assign c104 = c_arr[6][7];
    assign c105 = c_arr[6][8];   assign c106 = c_arr[6][9];   assign c107 = c_arr[6][10];  assign c108 = c_arr[6][11];  assign c109 = c_arr[6][12];  assign c110 = c_arr[6][13];  assign c111 = c_arr[6][14];  assign c112 = c_arr[6][15];
    assign c113 = c_arr[7][0];   assign c114 = c_arr[7][1];   assign c115 = c_arr[7][2];   assign c116 = c_arr[7][3];   assign c117 = c_arr[7][4];   assign c118 = c_arr[7][5];   assign c119 = c_arr[7][6];   assign c120 = c_arr[7][7];
    assign c121 = c_arr[7][8];   assign c122 = c_arr[7][9];   assign c123 = c_arr[7][10];  assign c124 = c_arr[7][11];  assign c125 = c_arr[7][12];  assign c126 = c_arr[7][13];  assign c127 = c_arr[7][14];  assign c128 = c_arr[7][15];
    assign c129 = c_arr[8][0];   assign c130 = c_arr[8][1];   assign c131 = c_arr[8][2];   assign c132 = c_arr[8][3];   assign c133 = c_arr[8][4];   assign c134 = c_arr[8][5];   assign c135 = c_arr[8][6];   assign c136 = c_arr[8][7];
    assign c137 = c_arr[8][8];   assign c138 = c_arr[8][9];   assign c139 = c_arr[8][10];  assign c140 = c_arr[8][11];  assign c141 = c_arr[8][12];  assign c142 = c_arr[8][13];  assign c143 = c_arr[8][14];  assign c144 = c_arr[8][15];
    assign c145 = c_arr[9][0];   assign c146 = c_arr[9][1];   assign c147 = c_arr[9][2];   assign c148 = c_arr[9][3];   assign c149 = c_arr[9][4];   assign c150 = c_arr[9][5];   assign c151 = c_arr[9][6];   assign c152 = c_arr[9][7];
    assign c153 = c_arr[9][8];   assign c154 = c_arr[9][9];   assign c155 = c_arr[9][10];  assign c156 = c_arr[9][11];  assign c157 = c_arr[9][12];  assign c158 = c_arr[9][13];  assign c159 = c_arr[9][14];  assign c160 = c_arr[9][15];
    assign c161 = c_arr[10][0];  assign c162 = c_arr[10][1];  assign c163 = c_arr[10][2];  assign c164 = c_arr[10][3];  assign c165 = c_arr[10][4];  assign c166 = c_arr[10][5];  assign c167 = c_arr[10][6];  assign c168 = c_arr[10][7];
    assign c169 = c_arr[10][8];  assign c170 = c_arr[10][9];  assign c171 = c_arr[10][10]; assign c172 = c_arr[10][11]; assign c173 = c_arr[10][12]; assign c174 = c_arr[10][13]; assign c175 = c_arr[10][14]; assign c176 = c_arr[10][15];
    assign c177 = c_arr[11][0];  assign c178 = c_arr[11][1];  assign c179 = c_arr[11][2];  assign c180 = c_arr[11][3];  assign c181 = c_arr[11][4];  assign c182 = c_arr[11][5];  assign c183 = c_arr[11][6];  assign c184 = c_arr[11][7];
    assign c185 = c_arr[11][8];  assign c186 = c_arr[11][9];  assign c187 = c_arr[11][10]; assign c188 = c_arr[11][11]; assign c189 = c_arr[11][12]; assign c190 = c_arr[11][13]; assign c191 = c_arr[11][14]; assign c192 = c_arr[11][15];
    assign c193 = c_arr[12][0];  assign c194 = c_arr[12][1];  assign c195 = c_arr[12][2];  assign c196 = c_arr[12][3];  assign c197 = c_arr[12][4];  assign c198 = c_arr[12][5];  assign c199 = c_arr[12][6];  assign c200 = c_arr[12][7];
    assign c201 = c_arr[12][8];  assign c202 = c_arr[12][9];  assign c203 = c_arr[12][10]; assign c204 = c_arr[12][11]; assign c205 = c_arr[12][12]; assign c206 = c_arr[12][13]; assign c207 = c_arr[12][14]; assign c208 = c_arr[12][15];
    assign c209 = c_arr[13][0];  assign c210 = c_arr[13][1];  assign c211 = c_arr[13][2];  assign c212 = c_arr[13][3];  assign c213 = c_arr[13][4];  assign c214 = c_arr[13][5];  assign c215 = c_arr[13][6];  assign c216 = c_arr[13][7];
    assign c217 = c_arr[13][8];  assign c218 = c_arr[13][9];  assign c219 = c_arr[13][10]; assign c220 = c_arr[13][11]; assign c221 = c_arr[13][12]; assign c222 = c_arr[13][13]; assign c223 = c_arr[13][14]; assign c224 = c_arr[13][15];
    assign c225 = c_arr[14][0];  assign c226 = c_arr[14][1];  assign c227 = c_arr[14][2];  assign c228 = c_arr[14][3];  assign c229 = c_arr[14][4];  assign c230 = c_arr[14][5];  assign c231 = c_arr[14][6];  assign c232 = c_arr[14][7];
    assign c233 = c_arr[14][8];  assign c234 = c_arr[14][9];  assign c235 = c_arr[14][10]; assign c236 = c_arr[14][11]; assign c237 = c_arr[14][12]; assign c238 = c_arr[14][13]; assign c239 = c_arr[14][14]; assign c240 = c_arr[14][15];
    assign c241 = c_arr[15][0];  assign c242 = c_arr[15][1];  assign c243 = c_arr[15][2];  assign c244 = c_arr[15][3];  assign c245 = c_arr[15][4];  assign c246 = c_arr[15][5];  assign c247 = c_arr[15][6];  assign c248 = c_arr[15][7];
    assign c249 = c_arr[15][8];  assign c250 = c_arr[15][9];  assign c251 = c_arr[15][10]; assign c252 = c_arr[15][11]; assign c253 = c_arr[15][12]; assign c254 = c_arr[15][13]; assign c255 = c_arr[15][14]; assign c256 = c_arr[15][15];

endmodule

// File: tb/tb_array_16x16.sv
// Bench for array_16x16: reset, single-PE pulse table, skew latency, matrix products via scoreboard, mid-run reset.
module tb_array_16x16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a [16];
    logic [15:0] b [16];
    logic [32:0] c [256];

    int total  = 0;
    int passed = 0;

    logic [15:0] ma [16][16];
    logic [15:0] mb [16][16];

    typedef struct {
        int          idx;
        logic [32:0] exp;
        int          due;
    } sb_t;

    typedef struct {
        logic [15:0] av;
        logic [15:0] bv;
        int          reps;
        logic [32:0] exp1;
    } pv_t;

    always #25 clk = ~clk;

    array_16x16 dut (
        .clk(clk), .rst(rst),
        .a1(a[0]), .a2(a[1]), .a3(a[2]), .a4(a[3]), .a5(a[4]), .a6(a[5]), .a7(a[6]), .a8(a[7]),
        .a9(a[8]), .a10(a[9]), .a11(a[10]), .a12(a[11]), .a13(a[12]), .a14(a[13]), .a15(a[14]), .a16(a[15]),
        .b1(b[0]), .b2(b[1]), .b3(b[2]), .b4(b[3]), .b5(b[4]), .b6(b[5]), .b7(b[6]), .b8(b[7]),
        .b9(b[8]), .b10(b[9]), .b11(b[10]), .b12(b[11]), .b13(b[12]), .b14(b[13]), .b15(b[14]), .b16(b[15]),
        .c1(c[0]), .c2(c[1]), .c3(c[2]), .c4(c[3]), .c5(c[4]), .c6(c[5]), .c7(c[6]), .c8(c[7]),
        .c9(c[8]), .c10(c[9]), .c11(c[10]), .c12(c[11]), .c13(c[12]), .c14(c[13]), .c15(c[14]), .c16(c[15]),
        .c17(c[16]), .c18(c[17]), .c19(c[18]), .c20(c[19]), .c21(c[20]), .c22(c[21]), .c23(c[22]), .c24(c[23]),
        .c25(c[24]), .c26(c[25]), .c27(c[26]), .c28(c[27]), .c29(c[28]), .c30(c[29]), .c31(c[30]), .c32(c[31]),
        .c33(c[32]), .c34(c[33]), .c35(c[34]), .c36(c[35]), .c37(c[36]), .c38(c[37]), .c39(c[38]), .c40(c[39]),
        .c41(c[40]), .c42(c[41]), .c43(c[42]), .c44(c[43]), .c45(c[44]), .c46(c[45]), .c47(c[46]), .c48(c[47]),
        .c49(c[48]), .c50(c[49]), .c51(c[50]), .c52(c[51]), .c53(c[52]), .c54(c[53]), .c55(c[54]), .c56(c[55]),
        .c57(c[56]), .c58(c[57]), .c59(c[58]), .c60(c[59]), .c61(c[60]), .c62(c[61]), .c63(c[62]), .c64(c[63]),
        .c65(c[64]), .c66(c[65]), .c67(c[66]), .c68(c[67]), .c69(c[68]), .c70(c[69]), .c71(c[70]), .c72(c[71]),
        .c73(c[72]), .c74(c[73]), .c75(c[74]), .c76(c[75]), .c77(c[76]), .c78(c[77]), .c79(c[78]), .c80(c[79]),
        .c81(c[80]), .c82(c[81]), .c83(c[82]), .c84(c[83]), .c85(c[84]), .c86(c[85]), .c87(c[86]), .c88(c[87]),
        .c89(c[88]), .c90(c[89]), .c91(c[90]), .c92(c[91]), .c93(c[92]), .c94(c[93]), .c95(c[94]), .c96(c[95]),
        .c97(c[96]), .c98(c[97]), .c99(c[98]), .c100(c[99]), .c101(c[100]), .c102(c[101]), .c103(c[102]), .c104(c[103]),
        .c105(c[104]), .c106(c[105]), .c107(c[106]), .c108(c[107]), .c109(c[108]), .c110(c[109]), .c111(c[110]), .c112(c[111]),
        .c113(c[112]), .c114(c[113]), .c115(c[114]), .c116(c[115]), .c117(c[116]), .c118(c[117]), .c119(c[118]), .c120(c[119]),
        .c121(c[120]), .c122(c[121]), .c123(c[122]), .c124(c[123]), .c125(c[124]), .c126(c[125]), .c127(c[126]), .c128(c[127]),
        .c129(c[128]), .c130(c[129]), .c131(c[130]), .c132(c[131]), .c133(c[132]), .c134(c[133]), .c135(c[134]), .c136(c[135]),
        .c137(c[136]), .c138(c[137]), .c139(c[138]), .c140(c[139]), .c141(c[140]), .c142(c[141]), .c143(c[142]), .c144(c[143]),
        .c145(c[144]), .c146(c[145]), .c147(c[146]), .c148(c[147]), .c149(c[148]), .c150(c[149]), .c151(c[150]), .c152(c[151]),
        .c153(c[152]), .c154(c[153]), .c155(c[154]), .c156(c[155]), .c157(c[156]), .c158(c[157]), .c159(c[158]), .c160(c[159]),
        .c161(c[160]), .c162(c[161]), .c163(c[162]), .c164(c[163]), .c165(c[164]), .c166(c[165]), .c167(c[166]), .c168(c[167]),
        .c169(c[168]), .c170(c[169]), .c171(c[170]), .c172(c[171]), .c173(c[172]), .c174(c[173]), .c175(c[174]), .c176(c[175]),
        .c177(c[176]), .c178(c[177]), .c179(c[178]), .c180(c[179]), .c181(c[180]), .c182(c[181]), .c183(c[182]), .c184(c[183]),
        .c185(c[184]), .c186(c[185]), .c187(c[186]), .c188(c[187]), .c189(c[188]), .c190(c[189]), .c191(c[190]), .c192(c[191]),
        .c193(c[192]), .c194(c[193]), .c195(c[194]), .c196(c[195]), .c197(c[196]), .c198(c[197]), .c199(c[198]), .c200(c[199]),
        .c201(c[200]), .c202(c[201]), .c203(c[202]), .c204(c[203]), .c205(c[204]), .c206(c[205]), .c207(c[206]), .c208(c[207]),
        .c209(c[208]), .c210(c[209]), .c211(c[210]), .c212(c[211]), .c213(c[212]), .c214(c[213]), .c215(c[214]), .c216(c[215]),
        .c217(c[216]), .c218(c[217]), .c219(c[218]), .c220(c[219]), .c221(c[220]), .c222(c[221]), .c223(c[222]), .c224(c[223]),
        .c225(c[224]), .c226(c[225]), .c227(c[226]), .c228(c[227]), .c229(c[228]), .c230(c[229]), .c231(c[230]), .c232(c[231]),
        .c233(c[232]), .c234(c[233]), .c235(c[234]), .c236(c[235]), .c237(c[236]), .c238(c[237]), .c239(c[238]), .c240(c[239]),
        .c241(c[240]), .c242(c[241]), .c243(c[242]), .c244(c[243]), .c245(c[244]), .c246(c[245]), .c247(c[246]), .c248(c[247]),
        .c249(c[248]), .c250(c[249]), .c251(c[250]), .c252(c[251]), .c253(c[252]), .c254(c[253]), .c255(c[254]), .c256(c[255])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [32:0] exp);
        total++;
        if (c[idx] === exp) passed++;
        else $display("FAIL %s c%0d: got 0x%0h expected 0x%0h", name, idx + 1, c[idx], exp);
    endtask

    task automatic check_all_zero(input string name);
        for (int n = 0; n < 256; n++) check(name, n, 33'd0);
    endtask

    task automatic zero_inputs();
        for (int n = 0; n < 16; n++) begin
            a[n] = '0;
            b[n] = '0;
        end
    endtask

    // Called just after a rising edge; the low pulse ends well before the next one.
    task automatic do_reset();
        zero_inputs();
        rst = 1'b0;
        #5;
        rst = 1'b1;
    endtask

    task automatic fill_rowsum();
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 16; k++) begin
                ma[i][k] = (i % 2 == 0) ? 16'(k + 1) : 16'(k + 17);
                mb[k][i] = 16'd1;
            end
    endtask

    // Feeds ma x mb skewed from the current cycle and checks each C(i,j) on the edge it becomes final.
    task automatic run_matmul(input string name);
        sb_t         q[$];
        sb_t         e;
        logic [32:0] acc;
        for (int s = 0; s <= 30; s++)
            for (int i = 0; i < 16; i++) begin
                if (s - i >= 0 && s - i < 16) begin
                    acc = '0;
                    for (int k = 0; k < 16; k++)
                        acc = acc + 33'(ma[i][k]) * 33'(mb[k][s - i]);
                    e.idx = i * 16 + (s - i);
                    e.exp = acc;
                    e.due = 16 + s;
                    q.push_back(e);
                end
            end
        for (int t = 0; t < 48; t++) begin
            for (int n = 0; n < 16; n++) begin
                a[n] = (t >= n && t - n < 16) ? ma[n][t - n] : 16'd0;
                b[n] = (t >= n && t - n < 16) ? mb[t - n][n] : 16'd0;
            end
            tick();
            while (q.size() > 0 && q[0].due == t + 1) begin
                e = q.pop_front();
                check(name, e.idx, e.exp);
            end
        end
        zero_inputs();
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL %s scoreboard: %0d entries left, expected 0", name, q.size());
    endtask

    pv_t pv[7];

    initial begin
        pv[0] = '{16'd3,     16'd5,     1, 33'd15};
        pv[1] = '{16'hFFFF,  16'hFFFF,  3, 33'h2FFFA0003};
        pv[2] = '{16'hFFFF,  16'hFFFF,  1, 33'h0FFFE0001};
        pv[3] = '{16'hFFFF,  16'hFFFF,  9, 33'h0FFEE0009};
        pv[4] = '{16'd0,     16'd1234,  4, 33'd0};
        pv[5] = '{16'd7,     16'd9,     2, 33'd126};
        pv[6] = '{16'hFFFF,  16'd1,     1, 33'h00000FFFF};

        // Reset held with random operands, then released with zero operands.
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin
            a[n] = 16'($urandom);
            b[n] = 16'($urandom);
        end
        for (int t = 0; t < 3; t++) tick();
        check_all_zero("reset_held");
        zero_inputs();
        rst = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        check_all_zero("reset_release");

        // Single-PE pulses on a1/b1.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            check("pulse_pre", 0, 33'd0);
            for (int r = 0; r < pv[v].reps; r++) begin
                a[0] = pv[v].av;
                b[0] = pv[v].bv;
                tick();
            end
            zero_inputs();
            check("pulse_c1", 0, pv[v].exp1);
            for (int t = 0; t < 18; t++) tick();
            check("pulse_c1_hold", 0, pv[v].exp1);
            check("pulse_c2", 1, 33'd0);
            check("pulse_c17", 16, 33'd0);
        end

        // a16 alone, b16 fifteen cycles later: the two pulses pass PE(16,16) at different edges.
        do_reset();
        for (int t = 0; t < 35; t++) begin
            a[15] = (t == 0)  ? 16'd1 : 16'd0;
            b[15] = (t == 15) ? 16'd1 : 16'd0;
            tick();
        end
        check("skew_unpaired_c256", 255, 33'd0);

        // Correctly skewed k=1 pair for PE(16,16): both driven 15 cycles in, product lands on edge 31.
        do_reset();
        for (int t = 0; t < 34; t++) begin
            a[15] = (t == 15) ? 16'd1 : 16'd0;
            b[15] = (t == 15) ? 16'd1 : 16'd0;
            tick();
            if (t + 1 == 30) check("skew_c256_early", 255, 33'd0);
            if (t + 1 == 31) check("skew_c256", 255, 33'd1);
        end
        check("skew_c241", 240, 33'd0);

        // Row-sum product.
        fill_rowsum();
        do_reset();
        run_matmul("rowsum");
        check("rowsum_c1", 0, 33'd136);
        check("rowsum_c16", 15, 33'd136);
        check("rowsum_c17", 16, 33'd392);
        check("rowsum_c32", 31, 33'd392);
        check("rowsum_c241", 240, 33'd392);
        check("rowsum_c256", 255, 33'd392);

        // Random full-range product, exercising modulo-2^33 wrap.
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 16; k++) begin
                ma[i][k] = 16'($urandom);
                mb[i][k] = 16'($urandom);
            end
        do_reset();
        run_matmul("random");

        // Mid-run reset during a row-sum feed, then a fresh row-sum run.
        fill_rowsum();
        do_reset();
        for (int t = 0; t < 20; t++) begin
            for (int n = 0; n < 16; n++) begin
                a[n] = (t >= n && t - n < 16) ? ma[n][t - n] : 16'd0;
                b[n] = (t >= n && t - n < 16) ? mb[t - n][n] : 16'd0;
            end
            tick();
        end
        check("midrun_before", 0, 33'd136);
        #9;
        rst = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        zero_inputs();
        #10;
        rst = 1'b1;
        run_matmul("midrun_restart");
        check("restart_c1", 0, 33'd136);
        check("restart_c256", 255, 33'd392);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
